seq_array_divider: RTL and testbench
====================================

Name: seq_array_divider

Overview:
- Sequential non-restoring divider: divides a 2W-bit dividend by a W-bit divisor.
- Reuses the division mode of the controlled add/subtract (CAS) cell, evaluating one array row per clock instead of a full combinational array.
- Complements the multiplier path of the modular array, giving a small-area divide unit with a start/done handshake.

Parameters:
- WIDTH, 4, divisor/quotient/remainder width W; dividend is 2W bits; W >= 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- DIVIDEND  input  2W  unsigned dividend; sampled on the accepting edge.
- DIVISOR  input  W  unsigned divisor; sampled on the accepting edge.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; results valid.
- QUOTIENT  output  W  unsigned quotient.
- REMAINDER  output  W  unsigned remainder.
- OVERFLOW  output  1  quotient does not fit in W bits, or divide by zero.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset (asynchronous, RST=0): state=IDLE; BUSY, DONE, OVERFLOW, QUOTIENT, REMAINDER all 0. Asserting RST mid-operation aborts immediately; no partial result is emitted.
- States: IDLE, ITER, CORR.
- IDLE, START=1 at an edge:
  - Overflow check: if DIVISOR==0 or DIVIDEND[2W-1:W] >= DIVISOR, stay IDLE. Next cycle: DONE=1, OVERFLOW=1, QUOTIENT=all ones, REMAINDER=DIVIDEND[W-1:0]. Latency 1 clock.
  - Otherwise: register D=DIVISOR. Set R (W+1-bit signed partial remainder) = {0, DIVIDEND[2W-1:W]}. Set low shift register = DIVIDEND[W-1:0], iteration counter = W-1, op=subtract. Go to ITER; BUSY=1.
- ITER, per edge:
  - R' = {R[W-1:0], next dividend bit, MSB first} minus D if op=subtract, plus D if op=add.
  - Quotient bit = ~R'[W], shifted into the quotient register LSB.
  - Next op = subtract if R'[W]==0, else add.
  - After W iterations (counter reaches 0), go to CORR.
- CORR, one edge:
  - If R[W]==1, R += D.
  - REMAINDER <= R[W-1:0], QUOTIENT <= quotient register, OVERFLOW <= 0, DONE <= 1, BUSY <= 0.
  - State -> IDLE.
- Latency: DONE is high in the cycle after edge W+1, counting the accepting edge as edge 0.
- DONE deasserts the next edge unless a new 1-clock overflow result pulses it again.
- START while BUSY is ignored, with no side effects.
- START in the DONE cycle (state IDLE) is accepted normally; back-to-back operation is legal.
- QUOTIENT, REMAINDER and OVERFLOW change only on DONE-producing edges and hold their value otherwise.
- DIVIDEND and DIVISOR may change freely while BUSY.

Optional Feature:
- Macro: DIV_ZERO_SKIP_EN.
- Defined: in IDLE, START with DIVIDEND==0 and DIVISOR!=0 bypasses ITER/CORR. Next cycle: DONE=1, QUOTIENT=0, REMAINDER=0, OVERFLOW=0. Latency 1 clock.
- Undefined: a zero dividend takes the normal W+1 clock path and produces the same values.

Decomposition:
- Package div_pkg contains:
  - state typedef (IDLE, ITER, CORR) with fixed 2-bit encoding;
  - op-select constants OP_SUB=1 and OP_ADD=0, matching the CAS cell P control polarity.
- Sub-module cas_row: combinational W+1-bit row of CAS cells.
  - Inputs: shifted R, D, op.
  - Outputs: R' and the carry-out chain.
  - Instantiated once and reused every ITER cycle; also used in CORR with op=add.

Test Plan (WIDTH=4):
- 1. DIVIDEND=100, DIVISOR=7 -> QUOTIENT=14, REMAINDER=2, OVERFLOW=0. DONE one cycle after edge 5; BUSY high for 5 cycles.
- 2. DIVIDEND=60, DIVISOR=15 -> QUOTIENT=4, REMAINDER=0. Then DIVIDEND=0x47, DIVISOR=9 -> QUOTIENT=7, REMAINDER=8, exercising the CORR add.
- 3. DIVIDEND=0x80, DIVISOR=7 -> OVERFLOW=1, QUOTIENT=0xF, REMAINDER=0x0, DONE after 1 clock. DIVIDEND=0x25, DIVISOR=0 -> OVERFLOW=1, QUOTIENT=0xF, REMAINDER=0x5.
- 4. START pulsed with new operands during ITER -> ignored; first result unchanged (100/7 -> 14 r 2).
- 5. RST=0 asynchronously during the 2nd iteration -> all outputs 0 immediately, no DONE. After release, START 100/7 -> correct result with nominal latency.
- 6. START asserted in the DONE cycle of 100/7 with 60/15 -> accepted; second DONE W+1 clocks later with QUOTIENT=4, REMAINDER=0. With DIV_ZERO_SKIP_EN defined, 0/5 -> DONE after 1 clock, QUOTIENT=0, REMAINDER=0.

Source files
------------

// File: rtl/seq_array_divider_pkg.sv
// Shared types for the sequential array divider: FSM state encoding and the
// CAS-row operation select (P control: 1 = subtract, 0 = add).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    CORR = 2'b10
  } state_t;

  localparam logic OP_SUB = 1'b1;
  localparam logic OP_ADD = 1'b0;

endpackage

// File: rtl/seq_array_divider_if.sv
// Request/result bundle of seq_array_divider plus read-only debug taps
// (FSM state and the CAS row carry chain).
interface seq_array_divider_if #(
  parameter int WIDTH = 4
);
  import div_pkg::*;

  // Handshake: START is a request sampled only while the divider is IDLE
  // (BUSY=0); it is ignored while BUSY=1. DONE is a one-cycle pulse marking
  // QUOTIENT/REMAINDER/OVERFLOW valid; those outputs hold until the next DONE.
  logic                 START;
  logic [2*WIDTH-1:0]   DIVIDEND;
  logic [WIDTH-1:0]     DIVISOR;
  logic                 BUSY;
  logic                 DONE;
  logic [WIDTH-1:0]     QUOTIENT;
  logic [WIDTH-1:0]     REMAINDER;
  logic                 OVERFLOW;
  state_t               state_dbg;
  logic [WIDTH:0]       carry_dbg;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, OVERFLOW, state_dbg, carry_dbg
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, OVERFLOW, state_dbg, carry_dbg
  );

endinterface

// File: rtl/seq_array_divider_cas_row.sv
// One row of WIDTH+1 controlled add/subtract cells: r_out = r_in + d (op=0)
// or r_in - d (op=1), with op feeding both the B inversion and carry-in.
module seq_array_divider_cas_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] d,
  input  logic             op,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH:0]   carry
);

  logic [WIDTH:0]   b;
  logic [WIDTH+1:0] c;

  always_comb begin
    b     = {1'b0, d} ^ {(WIDTH+1){op}};
    c     = '0;
    c[0]  = op;
    r_out = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      r_out[i] = r_in[i] ^ b[i] ^ c[i];
      c[i+1]   = (r_in[i] & b[i]) | (c[i] & (r_in[i] ^ b[i]));
    end
    carry = c[WIDTH+1:1];
  end

endmodule

// File: rtl/seq_array_divider.sv
// Sequential non-restoring divider, 2W/W bits, one CAS row per clock.
// Optional macro DIV_ZERO_SKIP_EN: a zero dividend finishes in one clock.
module seq_array_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  seq_array_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH:0]     r_q;
  logic [WIDTH-1:0]   low_q;
  logic [WIDTH-1:0]   q_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q;
  logic               done_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;

  logic [WIDTH-1:0]   dvd_hi, dvd_lo;
  logic               ovf_req, skip_req;
  logic [WIDTH:0]     row_in, row_out, row_carry;
  logic               row_op;

  assign dvd_hi  = bus.DIVIDEND[2*WIDTH-1:WIDTH];
  assign dvd_lo  = bus.DIVIDEND[WIDTH-1:0];
  // High half >= divisor means the quotient cannot fit in WIDTH bits.
  assign ovf_req = (bus.DIVISOR == '0) || (dvd_hi >= bus.DIVISOR);

`ifdef DIV_ZERO_SKIP_EN
  assign skip_req = (bus.DIVIDEND == '0) && (bus.DIVISOR != '0);
`else
  assign skip_req = 1'b0;
`endif

  seq_array_divider_cas_row #(.WIDTH(WIDTH)) u_row (
    .r_in  (row_in),
    .d     (d_q),
    .op    (row_op),
    .r_out (row_out),
    .carry (row_carry)
  );

  // CORR reuses the row as a plain add to restore a negative remainder.
  always_comb begin
    row_in    = {r_q[WIDTH-1:0], low_q[WIDTH-1]};
    row_op    = op_q;
    state_nxt = state;
    if (state == CORR) begin
      row_in = r_q;
      row_op = OP_ADD;
    end
    case (state)
      IDLE:    if (bus.START && !ovf_req && !skip_req) state_nxt = ITER;
      ITER:    if (cnt_q == '0) state_nxt = CORR;
      CORR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      d_q    <= '0;
      r_q    <= '0;
      low_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      op_q   <= OP_SUB;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            if (ovf_req) begin
              done_q <= 1'b1;
              ovf_q  <= 1'b1;
              quot_q <= '1;
              rem_q  <= dvd_lo;
            end else if (skip_req) begin
              done_q <= 1'b1;
              ovf_q  <= 1'b0;
              quot_q <= '0;
              rem_q  <= '0;
            end else begin
              d_q   <= bus.DIVISOR;
              r_q   <= {1'b0, dvd_hi};
              low_q <= dvd_lo;
              cnt_q <= CW'(WIDTH - 1);
              op_q  <= OP_SUB;
            end
          end
        end
        ITER: begin
          r_q   <= row_out;
          low_q <= {low_q[WIDTH-2:0], 1'b0};
          q_q   <= {q_q[WIDTH-2:0], ~row_out[WIDTH]};
          op_q  <= row_out[WIDTH] ? OP_ADD : OP_SUB;
          cnt_q <= cnt_q - CW'(1);
        end
        CORR: begin
          rem_q  <= r_q[WIDTH] ? row_out[WIDTH-1:0] : r_q[WIDTH-1:0];
          quot_q <= q_q;
          ovf_q  <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY      = (state != IDLE);
  assign bus.DONE      = done_q;
  assign bus.QUOTIENT  = quot_q;
  assign bus.REMAINDER = rem_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.state_dbg = state;
  assign bus.carry_dbg = row_carry;

endmodule

// File: tb/tb_seq_array_divider.sv
// Directed + random bench for seq_array_divider (WIDTH=4) against an
// arithmetic reference model; honours DIV_ZERO_SKIP_EN when defined.
module tb_seq_array_divider;
  import div_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] last_q, last_r;
  logic         last_ov;

  seq_array_divider_if #(.WIDTH(W)) bus();

  seq_array_divider #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; edges counted including the accepting edge.
  task automatic model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic ov, output int edges);
    int unsigned a, b;
    a = dvd;
    b = dvs;
    if (b == 0 || (a / b) > (2**W - 1)) begin
      q = '1; r = dvd[W-1:0]; ov = 1'b1; edges = 1;
    end else begin
      q = W'(a / b); r = W'(a % b); ov = 1'b0; edges = W + 2;
`ifdef DIV_ZERO_SKIP_EN
      if (a == 0) edges = 1;
`endif
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        input bit interfere);
    logic [W-1:0] eq, er;
    logic         eov;
    int           eedges, n;
    model(dvd, dvs, eq, er, eov, eedges);
    bus.DIVIDEND = dvd;
    bus.DIVISOR  = dvs;
    bus.START    = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.START    = 1'b0;
    bus.DIVIDEND = (2*W)'($urandom);
    bus.DIVISOR  = W'($urandom);
    n = 1;
    if (eedges > 1) begin
      check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
      check({tag, "_state"}, 32'(bus.state_dbg), 32'(ITER));
    end
    while (!bus.DONE && n < 20) begin
      if (interfere && n == 2) begin
        bus.START    = 1'b1;
        bus.DIVIDEND = (2*W)'(60);
        bus.DIVISOR  = W'(15);
      end else begin
        bus.START = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    bus.START = 1'b0;
    check({tag, "_done"}, 32'(bus.DONE), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(eedges));
    check({tag, "_q"}, 32'(bus.QUOTIENT), 32'(eq));
    check({tag, "_r"}, 32'(bus.REMAINDER), 32'(er));
    check({tag, "_ov"}, 32'(bus.OVERFLOW), 32'(eov));
    check({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
    last_q  = eq;
    last_r  = er;
    last_ov = eov;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); @(negedge clk);
    check({tag, "_done_clr"}, 32'(bus.DONE), 32'd0);
    check({tag, "_q_hold"}, 32'(bus.QUOTIENT), 32'(last_q));
    check({tag, "_r_hold"}, 32'(bus.REMAINDER), 32'(last_r));
    check({tag, "_ov_hold"}, 32'(bus.OVERFLOW), 32'(last_ov));
  endtask

  initial begin
    logic [2*W-1:0] rd;
    logic [W-1:0]   rv;
    bus.START    = 1'b0;
    bus.DIVIDEND = '0;
    bus.DIVISOR  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_q", 32'(bus.QUOTIENT), 32'd0);
    check("rst_r", 32'(bus.REMAINDER), 32'd0);
    check("rst_ov", 32'(bus.OVERFLOW), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic division and hold behaviour
    run_op("t1_100_7", 8'd100, 4'd7, 1'b0);
    idle_check("t1");
    run_op("t2_60_15", 8'd60, 4'd15, 1'b0);
    idle_check("t2");
    run_op("t2_47_9", 8'h47, 4'd9, 1'b0);
    idle_check("t2b");

    // Overflow and divide by zero
    run_op("t3_80_7", 8'h80, 4'd7, 1'b0);
    idle_check("t3");
    run_op("t3_25_0", 8'h25, 4'd0, 1'b0);
    idle_check("t3b");

    // START during ITER is ignored
    run_op("t4_ignore", 8'd100, 4'd7, 1'b1);
    idle_check("t4");

    // Asynchronous abort during the second iteration
    bus.DIVIDEND = 8'd100;
    bus.DIVISOR  = 4'd7;
    bus.START    = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.START = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.BUSY), 32'd0);
    check("t5_rst_q", 32'(bus.QUOTIENT), 32'd0);
    check("t5_rst_r", 32'(bus.REMAINDER), 32'd0);
    check("t5_rst_ov", 32'(bus.OVERFLOW), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_done", 32'(bus.DONE), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t5_after", 8'd100, 4'd7, 1'b0);

    // Back-to-back: second START issued in the DONE cycle
    run_op("t6_b2b", 8'd60, 4'd15, 1'b0);
    idle_check("t6");
    run_op("t6_zero", 8'd0, 4'd5, 1'b0);
    idle_check("t6z");

    // Random operands; even iterations avoid overflow
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        rv = W'($urandom_range(1, 2**W - 1));
        rd = {W'($urandom_range(0, int'(rv) - 1)), W'($urandom)};
      end else begin
        rv = W'($urandom);
        rd = (2*W)'($urandom);
      end
      run_op("rnd", rd, rv, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check("rnd");
    end
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
